ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 2400: clk cycles the host holds ps2 clock low before the start bit (at least 100 us at 24 MHz).
REQ-002 Parameter START_CYCLES, default 16: clk cycles data is held low with clock still low before clock is released.
REQ-003 Parameter TIMEOUT_CYCLES, default 48000: maximum clk cycles allowed between device clock falling edges (2 ms at 24 MHz).
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ps2_clk  in  1  PS/2 clock line as read from the pad.
REQ-007 ps2_data  in  1  PS/2 data line as read from the pad.
REQ-008 ps2_clk_oe  out  1  1 drives PS/2 clock low; 0 releases it (open-drain).
REQ-009 ps2_data_oe  out  1  1 drives PS/2 data low; 0 releases it (open-drain).
REQ-010 tx_data  in  8  command or data byte to send to the keyboard, for example 0xED for LEDs.
REQ-011 tx_start  in  1  single-cycle request, sampled only in IDLE.
REQ-012 busy  out  1  high from the cycle after an accepted tx_start until return to IDLE.
REQ-013 rx_inhibit  out  1  equals busy; tells the PS/2 receiver to discard bytes during transmission.
REQ-014 done  out  1  one-cycle pulse when a transfer ends normally, whether acknowledged or not.
REQ-015 ack_error  out  1  valid with done; 1 means the device did not pull data low at the ack edge.
REQ-016 timeout_error  out  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-017 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; the device clock falling edge (fe) SHALL be detected on the synchronized clock (previous 1, current 0).
REQ-018 States SHALL be IDLE, INHIBIT, START, SEND, ACK and WAIT_IDLE.
REQ-019 IDLE: tx_start=1 SHALL latch tx_data, compute odd parity (parity = ~^tx_data), load the cycle counter with INHIBIT_CYCLES and move to INHIBIT.
REQ-020 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0; when the counter expires, set ps2_data_oe=1 (start bit) and move to START.
REQ-021 START: ps2_clk_oe=1, ps2_data_oe=1 for START_CYCLES; then release the clock (ps2_clk_oe=0), clear the bit index to 0 and move to SEND.
REQ-022 SEND: on each fe the host SHALL place the next bit: index 0-7 data LSB first, 8 parity, 9 stop. ps2_data_oe = ~bit, so the stop bit releases the line; index increments on each fe.
REQ-023 SEND SHALL move to ACK on the fe that places the stop bit (index 9).
REQ-024 ACK: on the next fe (11th overall), ack_error SHALL be latched as the synchronized ps2_data value, and the block SHALL move to WAIT_IDLE.
REQ-025 WAIT_IDLE: when both synchronized lines are high, pulse done for one cycle with ack_error valid, then go to IDLE.
REQ-026 The timeout counter SHALL reload to TIMEOUT_CYCLES on entry to SEND and on every fe in SEND, ACK and WAIT_IDLE.
REQ-027 If the timeout counter reaches 0, the block SHALL release both lines, pulse timeout_error (done stays 0) and go to IDLE.
REQ-028 tx_start asserted while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 ps2_clk_oe and ps2_data_oe SHALL be registered outputs.
REQ-030 Counters SHALL be 16-bit and SHALL not wrap below 0.

Reset
REQ-031 reset SHALL asynchronously force state IDLE and set ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, done, ack_error and timeout_error to 0.
REQ-032 reset SHALL also clear the synchronizers to 1 and the bit index to 0; reset mid-transfer SHALL release both lines immediately.

Verification
REQ-033 Send 0xED with a device model that acks: data bits 1,0,1,1,0,1,1,1 then parity 1, stop 1; after the ack, done=1 and ack_error=0.
REQ-034 Send 0x02: parity bit 0; ps2_clk_oe stays high for exactly INHIBIT_CYCLES+START_CYCLES cycles (±1) before release.
REQ-035 Device model omits the ack (data high at the 11th fe): done=1 and ack_error=1.
REQ-036 Device never clocks after release: timeout_error pulses TIMEOUT_CYCLES (±2) cycles after SEND entry; both oe=0; busy=0.
REQ-037 tx_start=1 with 0x55 during SEND of 0xF4: only 0xF4 is transmitted, and only one done pulse occurs.
REQ-038 reset asserted at bit index 4: both oe=0 and busy=0 without waiting for a clk edge; a new transfer afterwards completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter.
//
// The host holds the PS/2 clock low to inhibit the device. It then pulls data
// low to form the start bit and releases the clock. The device then clocks
// out the frame. On each device falling edge the host places the next bit:
// 8 data bits LSB first, odd parity, then stop. On the 11th falling edge the
// host samples the device's ack bit. When both lines are idle high again, the
// transfer completes.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          asynchronous active-high reset
//   i_ps2_clk        PS/2 clock line as read from the pad
//   i_ps2_data       PS/2 data line as read from the pad
//   o_ps2_clk_oe     1 = pull PS/2 clock low, 0 = release (open drain)
//   o_ps2_data_oe    1 = pull PS/2 data low, 0 = release (open drain)
//   i_tx_data        byte to send to the device
//   i_tx_start       one-cycle request, honoured only while idle
//   o_busy           high from the cycle after acceptance until back in idle
//   o_rx_inhibit     copy of o_busy, tells the receiver to drop bytes
//   o_done           one-cycle pulse on normal completion
//   o_ack_error      valid with o_done; 1 = device did not ack
//   o_timeout_error  one-cycle pulse when the transfer is aborted
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2400,
  parameter int START_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_start,
  output logic       o_busy,
  output logic       o_rx_inhibit,
  output logic       o_done,
  output logic       o_ack_error,
  output logic       o_timeout_error
);

  localparam logic [15:0] L_INHIBIT = 16'(INHIBIT_CYCLES);
  localparam logic [15:0] L_START   = 16'(START_CYCLES);
  localparam logic [15:0] L_TIMEOUT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t      r_state;
  logic        r_clk_s1, r_clk_s2, r_clk_prev;
  logic        r_dat_s1, r_dat_s2;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic [3:0]  r_idx;
  logic [15:0] r_cnt;
  logic        r_ps2_clk_oe, r_ps2_data_oe, r_busy, r_done, r_ack_error, r_timeout_error;
  logic        w_fe;
  logic        w_tx_bit;

  // Two-flop synchronizers; idle-high lines reset to 1 so no false edge appears.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= i_ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fe = r_clk_prev & ~r_clk_s2;

  // Index 0-7 selects data bits, 8 selects parity, and anything higher is
  // the stop bit (1).
  always_comb begin
    w_tx_bit = 1'b1;
    if (r_idx < 4'd8)
      w_tx_bit = r_shift[r_idx[2:0]];
    else if (r_idx == 4'd8)
      w_tx_bit = r_parity;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_shift         <= 8'd0;
      r_parity        <= 1'b0;
      r_idx           <= 4'd0;
      r_cnt           <= 16'd0;
      r_ps2_clk_oe    <= 1'b0;
      r_ps2_data_oe   <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_ack_error     <= 1'b0;
      r_timeout_error <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_timeout_error <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ps2_clk_oe  <= 1'b0;
          r_ps2_data_oe <= 1'b0;
          if (i_tx_start) begin
            r_shift      <= i_tx_data;
            r_parity     <= ~^i_tx_data;
            r_cnt        <= L_INHIBIT;
            r_busy       <= 1'b1;
            r_ps2_clk_oe <= 1'b1;
            r_state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          // Exit at count 1 so that exactly INHIBIT_CYCLES cycles are spent here.
          if (r_cnt <= 16'd1) begin
            r_ps2_data_oe <= 1'b1;
            r_cnt         <= L_START;
            r_state       <= START;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        START: begin
          if (r_cnt <= 16'd1) begin
            r_ps2_clk_oe <= 1'b0;
            r_idx        <= 4'd0;
            r_cnt        <= L_TIMEOUT;
            r_state      <= SEND;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        SEND, ACK, WAIT_IDLE: begin
          if (r_state == WAIT_IDLE && r_clk_s2 && r_dat_s2) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_fe) begin
            r_cnt <= L_TIMEOUT;
            if (r_state == SEND) begin
              r_ps2_data_oe <= ~w_tx_bit;
              r_idx         <= r_idx + 4'd1;
              if (r_idx == 4'd9)
                r_state <= ACK;
            end else if (r_state == ACK) begin
              r_ack_error <= r_dat_s2;
              r_state     <= WAIT_IDLE;
            end
          end else if (r_cnt <= 16'd1) begin
            // Device stalled: release both lines and abort.
            r_ps2_clk_oe    <= 1'b0;
            r_ps2_data_oe   <= 1'b0;
            r_busy          <= 1'b0;
            r_timeout_error <= 1'b1;
            r_state         <= IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ps2_clk_oe    = r_ps2_clk_oe;
  assign o_ps2_data_oe   = r_ps2_data_oe;
  assign o_busy          = r_busy;
  assign o_rx_inhibit    = r_busy;
  assign o_done          = r_done;
  assign o_ack_error     = r_ack_error;
  assign o_timeout_error = r_timeout_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int STC = 4;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_start = 1'b0;
  logic       clk_oe, data_oe, busy, rx_inh, done, ack_err, to_err;

  // Open-drain bus: either side can pull each line low.
  wire line_clk  = dev_clk & ~clk_oe;
  wire line_data = dev_data & ~data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_CYCLES  (STC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_ps2_clk      (line_clk),
    .i_ps2_data     (line_data),
    .o_ps2_clk_oe   (clk_oe),
    .o_ps2_data_oe  (data_oe),
    .i_tx_data      (tx_data),
    .i_tx_start     (tx_start),
    .o_busy         (busy),
    .o_rx_inhibit   (rx_inh),
    .o_done         (done),
    .o_ack_error    (ack_err),
    .o_timeout_error(to_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_to     = 0;

  typedef struct packed {
    logic is_to;
    logic ack_err;
  } exp_t;

  exp_t       sb_q[$];     // expected transfer outcome, consumed by the monitor
  logic [8:0] frame_q[$];  // expected {parity, byte}, consumed by the device model
  exp_t       mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every end-of-transfer pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (done || to_err)) begin
      if (done) n_done++;
      if (to_err) n_to++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_end: done=%0d timeout_error=%0d with nothing outstanding", done, to_err);
      end else begin
        mon_e = sb_q.pop_front();
        chk("end_is_timeout", {31'd0, to_err}, {31'd0, mon_e.is_to});
        chk("end_is_done", {31'd0, done}, {31'd0, ~mon_e.is_to});
        if (!mon_e.is_to)
          chk("ack_error", {31'd0, ack_err}, {31'd0, mon_e.ack_err});
        $display("monitor: done=%0d ack_error=%0d timeout_error=%0d", done, ack_err, to_err);
      end
    end
  end

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Wait (bounded) until the host has released the clock in SEND.
  task automatic wait_release();
    int n;
    n = 0;
    while (!(busy && !clk_oe) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("release_seen", {30'd0, busy, clk_oe}, 32'd2);
  endtask

  task automatic dev_clock(output logic sampled);
    dev_clk = 1'b0;
    repeat (8) @(negedge clk);
    dev_clk = 1'b1;
    sampled = line_data;
    repeat (8) @(negedge clk);
  endtask

  // Device model: clock out 10 bits, sampling on rising edges, then the ack clock.
  task automatic dev_frame(input logic do_ack);
    logic [9:0] bits;
    logic [8:0] ef;
    logic       s;
    wait_release();
    chk("start_bit", {31'd0, line_data}, 32'd0);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clock(s);
      bits[k] = s;
    end
    if (frame_q.size() == 0) begin
      $display("FAIL frame_queue: device received a frame with nothing expected");
      $fatal(1);
    end
    ef = frame_q.pop_front();
    chk("data_byte", {24'd0, bits[7:0]}, {24'd0, ef[7:0]});
    chk("parity_bit", {31'd0, bits[8]}, {31'd0, ef[8]});
    chk("stop_bit", {31'd0, bits[9]}, 32'd1);
    if (do_ack) dev_data = 1'b0;
    repeat (3) @(negedge clk);
    dev_clock(s);
    repeat (4) @(negedge clk);
    dev_data = 1'b1;
    $display("device: received byte 0x%02h parity %0d stop %0d ack_driven %0d",
             bits[7:0], bits[8], bits[9], do_ack);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("return_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] b, input logic par, input logic ack, input logic measure);
    int n;
    frame_q.push_back({par, b});
    sb_q.push_back({1'b0, ~ack});
    pulse_start(b);
    if (measure) begin
      n = 0;
      while (clk_oe && n < 1000) begin
        n++;
        @(negedge clk);
      end
      chk_range("clk_low_cycles", n, INH + STC - 1, INH + STC + 1);
    end
    dev_frame(ack);
    wait_idle();
    $display("host: sent 0x%02h expecting parity %0d ack %0d", b, par, ack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic s;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", {31'd0, clk_oe}, 32'd0);
    chk("rst_data_oe", {31'd0, data_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rx_inhibit", {31'd0, rx_inh}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ack_error", {31'd0, ack_err}, 32'd0);
    chk("rst_timeout", {31'd0, to_err}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, acked.
    run_frame(8'hED, 1'b1, 1'b1, 1'b0);
    // 0x02: parity 0, also measure the clock-inhibit length.
    run_frame(8'h02, 1'b0, 1'b1, 1'b1);
    // 0xFF: parity 1, device withholds the ack.
    run_frame(8'hFF, 1'b1, 1'b0, 1'b0);

    // Timeout: device never clocks after release.
    sb_q.push_back({1'b1, 1'b0});
    pulse_start(8'h00);
    wait_release();
    chk("busy_during_send", {31'd0, rx_inh}, 32'd1);
    n = 0;
    while (!to_err && n < 2 * TMO) begin
      @(negedge clk);
      n++;
    end
    chk_range("timeout_delay", n, TMO - 2, TMO + 2);
    chk("to_clk_oe", {31'd0, clk_oe}, 32'd0);
    chk("to_data_oe", {31'd0, data_oe}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    $display("host: timeout transfer aborted after %0d cycles", n);
    repeat (5) @(negedge clk);

    // 0xF4 (parity 0) with a 0x55 request issued mid-SEND that must be dropped.
    frame_q.push_back({1'b0, 8'hF4});
    sb_q.push_back({1'b0, 1'b0});
    pulse_start(8'hF4);
    fork
      dev_frame(1'b1);
      begin
        wait_release();
        repeat (40) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
      end
    join
    wait_idle();
    repeat (60) @(negedge clk);
    chk("no_requeue_busy", {31'd0, busy}, 32'd0);
    chk("no_requeue_clk_oe", {31'd0, clk_oe}, 32'd0);
    $display("host: sent 0xF4 with ignored 0x55 request");

    // Reset mid-transfer at bit index 4 (0x30: bit 3 is 0, so data is held low).
    pulse_start(8'h30);
    wait_release();
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) dev_clock(s);
    chk("pre_reset_data_oe", {31'd0, data_oe}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_clk_oe", {31'd0, clk_oe}, 32'd0);
    chk("mid_reset_data_oe", {31'd0, data_oe}, 32'd0);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_rx_inhibit", {31'd0, rx_inh}, 32'd0);
    $display("host: reset applied mid-transfer of 0x30");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Recovery after reset: 0xA5, parity 1, acked.
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("frames_drained", frame_q.size(), 32'd0);
    chk("done_pulses", n_done, 32'd5);
    chk("timeout_pulses", n_to, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
